// File: rtl/eq2_bist_checker.sv
// On-chip self-test sequencer for the 2-bit equality comparator: sweeps the
// {a,b} patterns, checks aeqb against a==b, counts mismatches, latches the first.
module eq2_bist_checker #(
    parameter int N_VEC      = 16,
    parameter int SETTLE_CYC = 4,
    parameter int CW         = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       test_out,
    output logic [1:0] test_in0,
    output logic [1:0] test_in1,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic       fail_valid,
    output logic [3:0] first_fail
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [3:0]    IDX_LAST    = 4'(N_VEC - 1);
    localparam logic [4:0]    ERR_MAX     = 5'd31;

    // Golden response of a fault-free comparator for one stimulus pair.
    function automatic logic golden_eq(input logic [1:0] a, input logic [1:0] b);
        return (a == b);
    endfunction

    // Error counter increment that sticks at its maximum instead of wrapping.
    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        logic [4:0] r;
        if (v == ERR_MAX) begin
            r = ERR_MAX;
        end else begin
            r = v + 5'd1;
        end
        return r;
    endfunction

    state_t        state_r;
    state_t        next_state_s;
    logic [3:0]    idx_r;
    logic [3:0]    idx_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic [4:0]    err_cnt_r;
    logic [4:0]    err_cnt_s;
    logic          fail_valid_r;
    logic          fail_valid_s;
    logic [3:0]    first_fail_r;
    logic [3:0]    first_fail_s;
    logic          busy_r;
    logic          busy_s;
    logic          done_r;
    logic          done_s;
    logic          pass_r;
    logic          pass_s;
    logic          launch_s;
    logic          mismatch_s;

    // A run may only be launched from the two resting states.
    always_comb begin
        launch_s = start && ((state_r == IDLE) || (state_r == DONE));
    end

    // test_out is only looked at in CHECK, so SETTLE glitches never count.
    always_comb begin
        if (state_r == CHECK) begin
            mismatch_s = (test_out != golden_eq(idx_r[3:2], idx_r[1:0]));
        end else begin
            mismatch_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (launch_s) begin
                    next_state_s = SETTLE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    next_state_s = CHECK;
                end else begin
                    next_state_s = SETTLE;
                end
            end
            CHECK: begin
                if (idx_r == IDX_LAST) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = SETTLE;
                end
            end
            DONE: begin
                if (launch_s) begin
                    next_state_s = SETTLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Output/datapath logic: next values of every registered output.
    always_comb begin
        idx_s        = idx_r;
        cnt_s        = cnt_r;
        err_cnt_s    = err_cnt_r;
        fail_valid_s = fail_valid_r;
        first_fail_s = first_fail_r;
        case (state_r)
            IDLE, DONE: begin
                if (launch_s) begin
                    idx_s        = 4'd0;
                    cnt_s        = '0;
                    err_cnt_s    = 5'd0;
                    fail_valid_s = 1'b0;
                    first_fail_s = 4'd0;
                end else begin
                    idx_s = idx_r;
                end
            end
            SETTLE: begin
                cnt_s = cnt_r + CW'(1);
            end
            CHECK: begin
                if (mismatch_s) begin
                    err_cnt_s = sat_inc(err_cnt_r);
                    if (!fail_valid_r) begin
                        fail_valid_s = 1'b1;
                        first_fail_s = idx_r;
                    end else begin
                        fail_valid_s = 1'b1;
                    end
                end else begin
                    err_cnt_s = err_cnt_r;
                end
                // Last pattern stays on the stimulus outputs while in DONE.
                if (idx_r != IDX_LAST) begin
                    idx_s = idx_r + 4'd1;
                    cnt_s = '0;
                end else begin
                    idx_s = idx_r;
                end
            end
            default: begin
                idx_s = idx_r;
            end
        endcase
        busy_s = (next_state_s == SETTLE) || (next_state_s == CHECK);
        done_s = (next_state_s == DONE);
        pass_s = done_s && (err_cnt_s == 5'd0);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_r        <= 4'd0;
            cnt_r        <= '0;
            err_cnt_r    <= 5'd0;
            fail_valid_r <= 1'b0;
            first_fail_r <= 4'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
        end else begin
            idx_r        <= idx_s;
            cnt_r        <= cnt_s;
            err_cnt_r    <= err_cnt_s;
            fail_valid_r <= fail_valid_s;
            first_fail_r <= first_fail_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            pass_r       <= pass_s;
        end
    end

    assign test_in0   = idx_r[3:2];
    assign test_in1   = idx_r[1:0];
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign err_cnt    = err_cnt_r;
    assign fail_valid = fail_valid_r;
    assign first_fail = first_fail_r;

endmodule

// File: tb/tb_eq2_bist_checker.sv
// Scoreboard bench for eq2_bist_checker: a default instance and a short
// N_VEC=8/SETTLE_CYC=1 instance, each driven by a modelled comparator.
module tb_eq2_bist_checker;

    typedef struct {
        logic [4:0] err;
        logic       fv;
        logic [3:0] ff;
        logic       pas;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       start6 = 1'b0;
    logic       test_out;
    logic       test_out6;
    logic       glitch6 = 1'b0;
    int         mode = 0;

    logic [1:0] in0, in1, in0_6, in1_6;
    logic       busy, done, pass, fail_valid;
    logic       busy6, done6, pass6, fail_valid6;
    logic [4:0] err_cnt, err_cnt6;
    logic [3:0] first_fail, first_fail6;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    exp_t q0[$];
    exp_t q6[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    eq2_bist_checker dut (
        .clk(clk), .reset(reset), .start(start), .test_out(test_out),
        .test_in0(in0), .test_in1(in1), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_valid(fail_valid), .first_fail(first_fail)
    );

    eq2_bist_checker #(.N_VEC(8), .SETTLE_CYC(1), .CW(3)) dut6 (
        .clk(clk), .reset(reset), .start(start6), .test_out(test_out6),
        .test_in0(in0_6), .test_in1(in1_6), .busy(busy6), .done(done6), .pass(pass6),
        .err_cnt(err_cnt6), .fail_valid(fail_valid6), .first_fail(first_fail6)
    );

    // Comparator model: 0 good, 1 stuck-at-0, 2 inverted, 3 wrong only for a=1,b=2.
    function automatic logic cmp_model(input int m, input logic [1:0] a, input logic [1:0] b);
        case (m)
            1: return 1'b0;
            2: return (a != b);
            3: return ((a == 2'd1) && (b == 2'd2)) ? 1'b1 : (a == b);
            default: return (a == b);
        endcase
    endfunction

    always_comb test_out  = cmp_model(mode, in0, in1);
    always_comb test_out6 = cmp_model(3, in0_6, in1_6) ^ glitch6;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor for the default instance.
    logic busy_q = 1'b0, done_q = 1'b0;
    int   t_busy = 0;
    always @(negedge clk) begin
        if (busy && !busy_q) t_busy <= cyc;
        if (done && !done_q) begin
            if (q0.size() == 0) begin
                chk("dut_unexpected_done", 1, 0);
            end else begin
                chk("dut_err_cnt",    int'(err_cnt),    int'(q0[0].err));
                chk("dut_fail_valid", int'(fail_valid), int'(q0[0].fv));
                chk("dut_first_fail", int'(first_fail), int'(q0[0].ff));
                chk("dut_pass",       int'(pass),       int'(q0[0].pas));
                chk("dut_busy_low",   int'(busy),       0);
                chk("dut_latency",    cyc - t_busy,     q0[0].lat);
                void'(q0.pop_front());
            end
        end
        busy_q <= busy;
        done_q <= done;
    end

    // Monitor for the short instance.
    logic busy6_q = 1'b0, done6_q = 1'b0;
    int   t_busy6 = 0;
    always @(negedge clk) begin
        if (busy6 && !busy6_q) t_busy6 <= cyc;
        if (done6 && !done6_q) begin
            if (q6.size() == 0) begin
                chk("dut6_unexpected_done", 1, 0);
            end else begin
                chk("dut6_err_cnt",    int'(err_cnt6),    int'(q6[0].err));
                chk("dut6_fail_valid", int'(fail_valid6), int'(q6[0].fv));
                chk("dut6_first_fail", int'(first_fail6), int'(q6[0].ff));
                chk("dut6_pass",       int'(pass6),       int'(q6[0].pas));
                chk("dut6_latency",    cyc - t_busy6,     q6[0].lat);
                void'(q6.pop_front());
            end
        end
        busy6_q <= busy6;
        done6_q <= done6;
    end

    task automatic push0(input logic [4:0] e, input logic fv, input logic [3:0] ff,
                         input logic p, input int lat);
        exp_t x;
        x.err = e; x.fv = fv; x.ff = ff; x.pas = p; x.lat = lat;
        q0.push_back(x);
    endtask

    task automatic pulse_start;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("dut_done_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_test_in0"},   int'(in0),        0);
        chk({tag, "_test_in1"},   int'(in1),        0);
        chk({tag, "_busy"},       int'(busy),       0);
        chk({tag, "_done"},       int'(done),       0);
        chk({tag, "_pass"},       int'(pass),       0);
        chk({tag, "_err_cnt"},    int'(err_cnt),    0);
        chk({tag, "_fail_valid"}, int'(fail_valid), 0);
        chk({tag, "_first_fail"}, int'(first_fail), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        // Fault-free comparator.
        mode = 0;
        push0(5'd0, 1'b0, 4'd0, 1'b1, 80);
        pulse_start();
        wait_done(200);

        // Stuck-at-0: misses on the four a==b patterns 0,5,10,15.
        mode = 1;
        push0(5'd4, 1'b1, 4'd0, 1'b0, 80);
        pulse_start();
        wait_done(200);

        // Restart from DONE with errors pending must clear them; inverted DUT.
        mode = 2;
        push0(5'd16, 1'b1, 4'd0, 1'b0, 80);
        pulse_start();
        chk("restart_done_drop",   int'(done),       0);
        chk("restart_busy",        int'(busy),       1);
        chk("restart_err_clear",   int'(err_cnt),    0);
        chk("restart_fv_clear",    int'(fail_valid), 0);
        wait_done(200);

        // Reset in the middle of a stuck-at-0 run, then a clean rerun.
        mode = 1;
        pulse_start();
        repeat (36) @(negedge clk);
        chk("abort_pre_fail_valid", int'(fail_valid), 1);
        #2 reset = 1'b1;
        #1 chk_all_zero("abort");
        @(negedge clk) reset = 1'b0;
        mode = 0;
        push0(5'd0, 1'b0, 4'd0, 1'b1, 80);
        pulse_start();
        wait_done(200);

        // start held high, then re-pulsed, while busy: no restart.
        mode = 1;
        push0(5'd4, 1'b1, 4'd0, 1'b0, 80);
        @(negedge clk) start = 1'b1;
        repeat (30) @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        pulse_start();
        wait_done(200);

        // Short instance: fault at idx 6 only, glitch during SETTLE of idx 3.
        begin
            exp_t x;
            x.err = 5'd1; x.fv = 1'b1; x.ff = 4'd6; x.pas = 1'b0; x.lat = 16;
            q6.push_back(x);
        end
        @(negedge clk) start6 = 1'b1;
        @(negedge clk) start6 = 1'b0;
        repeat (6) @(negedge clk);
        glitch6 = 1'b1;
        @(negedge clk) glitch6 = 1'b0;
        begin
            int n = 0;
            while (!done6 && n < 60) begin
                @(negedge clk);
                n++;
            end
            if (!done6) chk("dut6_done_timeout", 0, 1);
        end
        repeat (2) @(negedge clk);

        chk("q0_drained", q0.size(), 0);
        chk("q6_drained", q6.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
